lfsr_seq_ctrl: RTL and testbench

Sequencing and arbitration controller for the 26-bit LFSR datapath. Two requesters share one LFSR instance. The controller round-robin arbitrates between them, optionally reseeds the LFSR through its `load`/`din` pins, lets it free-run a programmed number of steps, then returns the sampled 26-bit word over a valid/ready response channel tagged with the requester ID.

---
 rtl/lfsr_seq_ctrl.sv | 153 +++++++++++++++
 tb/tb_lfsr_seq_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_seq_ctrl.sv
// lfsr_seq_ctrl
// Sequencing and arbitration controller for a shared 26-bit LFSR.
// Two requesters are round-robin arbitrated. The winner optionally reseeds
// the LFSR, the LFSR free-runs STEPS steps, and the sampled word is returned
// on a valid/ready channel tagged with the requester ID.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   req[1:0]           per-requester request, held until its handshake
//   reseed[1:0]        per-requester reseed flag, sampled at grant
//   seed0, seed1       per-requester seed (LFSR din bit order)
//   lfsr_load/din      drive the LFSR load/din pins (active only in LOAD)
//   lfsr_q             LFSR state
//   rsp_valid/ready    response handshake
//   rsp_data, rsp_id   captured LFSR word and served requester
//   busy               high whenever the controller is not IDLE
//
// Configuration macro: LFSR_SEED_GUARD_EN
//   defined   -> a registered all-zero seed is replaced by SEED_DFLT in LOAD
//   undefined -> the seed is passed through unmodified

module lfsr_seq_ctrl #(
  parameter int unsigned STEPS     = 8,
  parameter logic [0:25] SEED_DFLT = 26'h2AA5C81
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  input  logic [1:0]  reseed,
  input  logic [0:25] seed0,
  input  logic [0:25] seed1,
  output logic        lfsr_load,
  output logic [0:25] lfsr_din,
  input  logic [0:25] lfsr_q,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [0:25] rsp_data,
  output logic        rsp_id,
  output logic        busy
);

  localparam logic [7:0] STEPS_W = 8'(STEPS);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, RESP} state_t;

  state_t      state_q, state_d;
  logic        last_q, last_d;
  logic        id_q, id_d;
  logic [0:25] seed_q, seed_d;
  logic [0:25] data_q, data_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        gnt;
  logic [0:25] seed_eff;

  // Seed presented on lfsr_din during LOAD; an all-zero seed would lock
  // an XOR LFSR, so the guard build substitutes the default seed.
  always_comb begin
`ifdef LFSR_SEED_GUARD_EN
    seed_eff = (seed_q == '0) ? SEED_DFLT : seed_q;
`else
    seed_eff = seed_q;
`endif
  end

  // Round-robin pick: on contention the requester that did not win last
  // time gets the grant; otherwise the lone requester wins.
  always_comb begin
    gnt = (req == 2'b11) ? ~last_q : req[1];
  end

  // Next-state logic. RUN counts cnt down from STEPS to 0 inclusive, so it
  // lasts STEPS+1 cycles; the LFSR word is captured on the way to RESP.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    id_d    = id_q;
    seed_d  = seed_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (req != 2'b00) begin
          last_d = gnt;
          id_d   = gnt;
          seed_d = gnt ? seed1 : seed0;
          if (reseed[gnt]) begin
            state_d = LOAD;
          end else begin
            state_d = RUN;
            cnt_d   = STEPS_W;
          end
        end
      end
      LOAD: begin
        state_d = RUN;
        cnt_d   = STEPS_W;
      end
      RUN: begin
        if (cnt_q == 8'd0) begin
          state_d = RESP;
          data_d  = lfsr_q;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the state register so that an asynchronous
  // reset clears them immediately.
  always_comb begin
    lfsr_load = 1'b0;
    lfsr_din  = '0;
    rsp_valid = 1'b0;
    busy      = (state_q != IDLE);
    rsp_data  = data_q;
    rsp_id    = id_q;
    if (state_q == LOAD) begin
      lfsr_load = 1'b1;
      lfsr_din  = seed_eff;
    end
    if (state_q == RESP) begin
      rsp_valid = 1'b1;
    end
  end

  // State registers. last resets to 1 so requester 0 wins the first
  // contention after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      id_q    <= 1'b0;
      seed_q  <= '0;
      data_q  <= '0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      seed_q  <= seed_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// tb_lfsr_seq_ctrl
// Bench for lfsr_seq_ctrl. Provides the shared LFSR itself (load/step) and
// a transaction-level reference model that predicts every output from the
// grant time, latency arithmetic and the LFSR stepping rule.

module tb_lfsr_seq_ctrl;

  localparam int          STEPS     = 8;
  localparam logic [0:25] SEED_DFLT = 26'h2AA5C81;
`ifdef LFSR_SEED_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [1:0]  req;
  logic [1:0]  reseed;
  logic [0:25] seed0;
  logic [0:25] seed1;
  logic        lfsr_load;
  logic [0:25] lfsr_din;
  logic [0:25] lfsr_q = 26'h1234567;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [0:25] rsp_data;
  logic        rsp_id;
  logic        busy;

  int vectors    = 0;
  int miscompares = 0;

  lfsr_seq_ctrl #(.STEPS(STEPS), .SEED_DFLT(SEED_DFLT)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .reseed    (reseed),
    .seed0     (seed0),
    .seed1     (seed1),
    .lfsr_load (lfsr_load),
    .lfsr_din  (lfsr_din),
    .lfsr_q    (lfsr_q),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One LFSR step: x^26+x^6+x^2+x+1 Fibonacci form, feedback enters index 0.
  function automatic logic [0:25] lfsr_step(input logic [0:25] v);
    logic fb;
    fb = v[25] ^ v[5] ^ v[1] ^ v[0];
    return {fb, v[0:24]};
  endfunction

  function automatic logic [0:25] step_n(input logic [0:25] v, input int n);
    logic [0:25] r;
    r = v;
    for (int i = 0; i < n; i++) r = lfsr_step(r);
    return r;
  endfunction

  // The shared LFSR datapath.
  always @(posedge clk) begin
    lfsr_q <= lfsr_load ? lfsr_din : lfsr_step(lfsr_q);
  end

  // Reference model state: one outstanding transaction described by the
  // number of cycles since its grant and the cycle at which valid rises.
  bit          m_active;
  int          m_n;
  int          m_lat;
  bit          m_rs;
  bit          m_id;
  bit          m_last;
  logic [0:25] m_seed_eff;
  logic [0:25] m_data;
  bit          hs_now;
  bit          hs_id_m;
  logic        hs_dut_id;
  logic [0:25] hs_dut_data;
  int          load_count;
  int          busy_count;
  logic [0:25] din_at_load;

  task automatic checkEq(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    m_active = 1'b0;
    m_n      = 0;
    m_last   = 1'b1;
    hs_now   = 1'b0;
  endtask

  task automatic applyStimulus(input logic [1:0] r, input logic [1:0] rs,
                               input logic [0:25] s0, input logic [0:25] s1,
                               input logic rdy);
    req       = r;
    reseed    = rs;
    seed0     = s0;
    seed1     = s1;
    rsp_ready = rdy;
  endtask

  // Compares the DUT outputs of the current cycle against the model.
  task automatic checkOutput();
    bit exp_load;
    bit exp_valid;
    if (lfsr_load === 1'b1) begin
      load_count++;
      din_at_load = lfsr_din;
    end
    if (busy === 1'b1) busy_count++;
    if (!m_active) begin
      checkEq("idle_busy", busy, 0);
      checkEq("idle_valid", rsp_valid, 0);
      checkEq("idle_load", lfsr_load, 0);
      checkEq("idle_din", lfsr_din, 0);
    end else begin
      exp_load  = m_rs && (m_n == 1);
      exp_valid = (m_n >= m_lat);
      checkEq("busy", busy, 1);
      checkEq("load", lfsr_load, exp_load);
      checkEq("din", lfsr_din, exp_load ? m_seed_eff : 26'h0);
      checkEq("valid", rsp_valid, exp_valid);
      if (exp_valid) begin
        checkEq("rsp_data", rsp_data, m_data);
        checkEq("rsp_id", rsp_id, m_id);
      end
    end
  endtask

  // Advances the model using the inputs the DUT samples at the next edge.
  task automatic advanceModel();
    bit          w;
    logic [0:25] s;
    hs_now = 1'b0;
    if (m_active) begin
      if (m_n >= m_lat && rsp_ready) begin
        m_active    = 1'b0;
        hs_now      = 1'b1;
        hs_id_m     = m_id;
        hs_dut_id   = rsp_id;
        hs_dut_data = rsp_data;
      end else begin
        m_n++;
      end
    end else if (req != 2'b00) begin
      if (req[0] && req[1]) w = (m_last == 1'b0) ? 1'b1 : 1'b0;
      else if (req[0])      w = 1'b0;
      else                  w = 1'b1;
      m_last     = w;
      m_id       = w;
      m_rs       = reseed[w];
      s          = w ? seed1 : seed0;
      m_seed_eff = (GUARD && s == 26'h0) ? SEED_DFLT : s;
      m_lat      = STEPS + 2 + (m_rs ? 1 : 0);
      m_data     = m_rs ? step_n(m_seed_eff, STEPS) : step_n(lfsr_q, STEPS + 1);
      m_active   = 1'b1;
      m_n        = 1;
    end
  endtask

  // One clock: check at the falling edge, then return just after the
  // rising edge so callers drive inputs for the following cycle.
  task automatic cycle();
    @(negedge clk);
    if (!rst) begin
      checkOutput();
      advanceModel();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic runUntilHs(input int maxc, output bit done);
    done = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      cycle();
      if (hs_now) begin
        done = 1'b1;
        break;
      end
    end
  endtask

  task automatic resetDut();
    rst = 1'b1;
    applyStimulus(2'b00, 2'b00, 26'h0, 26'h0, 1'b0);
    @(negedge clk);
    checkEq("rst_busy", busy, 0);
    checkEq("rst_valid", rsp_valid, 0);
    checkEq("rst_load", lfsr_load, 0);
    checkEq("rst_din", lfsr_din, 0);
    checkEq("rst_data", rsp_data, 0);
    checkEq("rst_id", rsp_id, 0);
    @(negedge clk);
    modelReset();
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit          done;
    logic [31:0] r;
    logic [0:25] s;
    rst = 1'b1;
    applyStimulus(2'b00, 2'b00, 26'h0, 26'h0, 1'b0);
    modelReset();
    resetDut();

    // Hand-computed pin: seed 1 stepped 8 times is 26'h26C0000.
    load_count = 0;
    applyStimulus(2'b01, 2'b01, 26'h0000001, 26'h0, 1'b1);
    runUntilHs(60, done);
    req = 2'b00;
    checkEq("pin_done", done, 1);
    checkEq("pin_data", hs_dut_data, 26'h26C0000);
    checkEq("pin_id", hs_dut_id, 0);
    checkEq("pin_load_pulses", load_count, 1);

    // Reseed with the default seed, model-checked.
    cycle();
    applyStimulus(2'b01, 2'b01, 26'h2AA5C81, 26'h0, 1'b1);
    runUntilHs(60, done);
    req = 2'b00;
    checkEq("seed_done", done, 1);

    // Both requesting from reset: grants alternate 0,1,0,1.
    resetDut();
    applyStimulus(2'b11, 2'b00, 26'h0, 26'h0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      runUntilHs(60, done);
      checkEq("alt_done", done, 1);
      checkEq("alt_id", hs_dut_id, k % 2);
    end
    req = 2'b00;
    cycle();

    // Stall in RESP for 20 cycles while requester 1 waits.
    applyStimulus(2'b01, 2'b00, 26'h0, 26'h0, 1'b0);
    done = 1'b0;
    for (int i = 0; i < 60; i++) begin
      cycle();
      if (m_active && m_n >= m_lat) begin
        done = 1'b1;
        break;
      end
    end
    checkEq("stall_reach", done, 1);
    req = 2'b11;
    busy_count = 0;
    repeat (20) cycle();
    checkEq("stall_busy", busy_count, 20);
    rsp_ready = 1'b1;
    runUntilHs(5, done);
    checkEq("stall_hs0", done, 1);
    checkEq("stall_id0", hs_dut_id, 0);
    req = 2'b10;
    runUntilHs(60, done);
    req = 2'b00;
    checkEq("stall_hs1", done, 1);
    checkEq("stall_id1", hs_dut_id, 1);

    // Zero seed on requester 1.
    cycle();
    din_at_load = 26'h3FFFFFF;
    applyStimulus(2'b10, 2'b10, 26'h0, 26'h0, 1'b1);
    runUntilHs(60, done);
    req = 2'b00;
    checkEq("zero_done", done, 1);
    if (GUARD) begin
      checkEq("zero_din_guard", din_at_load, 26'h2AA5C81);
    end else begin
      checkEq("zero_din", din_at_load, 26'h0);
      checkEq("zero_data", hs_dut_data, 26'h0);
    end

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      for (int k = 0; k < 2; k++) begin
        if (hs_now && hs_id_m == k[0]) begin
          req[k] = 1'b0;
        end else if (!req[k] && ($urandom % 3 == 0)) begin
          r = $urandom;
          s = (($urandom % 8) == 0) ? 26'h0 : r[25:0];
          req[k]    = 1'b1;
          reseed[k] = $urandom % 2;
          if (k == 0) seed0 = s;
          else        seed1 = s;
        end
      end
      rsp_ready = ($urandom % 4) != 0;
      cycle();
    end

    // Asynchronous reset during RUN, then contention must favour 0.
    resetDut();
    applyStimulus(2'b01, 2'b00, 26'h0, 26'h0, 1'b1);
    done = 1'b0;
    for (int i = 0; i < 60; i++) begin
      cycle();
      if (m_active && m_n == 4) begin
        done = 1'b1;
        break;
      end
    end
    checkEq("mid_reach", done, 1);
    #1;
    rst = 1'b1;
    #1;
    checkEq("mid_rst_busy", busy, 0);
    checkEq("mid_rst_valid", rsp_valid, 0);
    checkEq("mid_rst_load", lfsr_load, 0);
    modelReset();
    applyStimulus(2'b11, 2'b00, 26'h0, 26'h0, 1'b1);
    cycle();
    rst = 1'b0;
    runUntilHs(60, done);
    checkEq("post_rst_done", done, 1);
    checkEq("post_rst_first_id", hs_dut_id, 0);
    req = 2'b00;
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
